// File: rtl/ov7670_config_sequencer.sv
// Walks a 256-entry config ROM and issues one SCCB register write per entry (FFF0 = pause, FFFF = end).
// Optional transmitter watchdog: define SCCB_CFG_TIMEOUT_EN.
module ov7670_config_sequencer #(
   parameter int DELAY_CYCLES   = 1_000_000,
   parameter int TIMEOUT_CYCLES = 65_535
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic [7:0]  rom_addr,
   input  logic [15:0] rom_dout,
   input  logic        sccb_ready,
   output logic        sccb_start,
   output logic [7:0]  sccb_reg,
   output logic [7:0]  sccb_data,
   output logic        busy,
   output logic        done,
   output logic        error
);

   typedef enum logic [2:0] {
      IDLE, FETCH, DECODE, WAIT_READY, WAIT_ACCEPT, DELAY, FINISH
   } state_t;

   state_t      state;
   logic [31:0] delay_cnt;

`ifdef SCCB_CFG_TIMEOUT_EN
   logic [31:0] wd_cnt;
`else
   // No watchdog in this build; the parameter is deliberately unused.
   logic unused_timeout;
   assign unused_timeout = ^32'(TIMEOUT_CYCLES);
   assign error = 1'b0;
`endif

   // Single sequencer FSM; every output is registered and sccb_start defaults low each cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         rom_addr   <= 8'd0;
         sccb_start <= 1'b0;
         sccb_reg   <= 8'd0;
         sccb_data  <= 8'd0;
         busy       <= 1'b0;
         done       <= 1'b0;
         delay_cnt  <= 32'd0;
`ifdef SCCB_CFG_TIMEOUT_EN
         wd_cnt     <= 32'd0;
         error      <= 1'b0;
`endif
      end else begin
         sccb_start <= 1'b0;
         case (state)
            IDLE, FINISH: begin
               if (start) begin
                  rom_addr <= 8'd0;
                  done     <= 1'b0;
                  busy     <= 1'b1;
`ifdef SCCB_CFG_TIMEOUT_EN
                  error    <= 1'b0;
`endif
                  state    <= FETCH;
               end
            end
            FETCH: state <= DECODE;
            DECODE: begin
`ifdef SCCB_CFG_TIMEOUT_EN
               wd_cnt <= 32'd0;
`endif
               if (rom_dout == 16'hFFFF) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= FINISH;
               end else if (rom_dout == 16'hFFF0) begin
                  delay_cnt <= 32'(DELAY_CYCLES - 1);
                  state     <= DELAY;
               end else begin
                  sccb_reg  <= rom_dout[15:8];
                  sccb_data <= rom_dout[7:0];
                  state     <= WAIT_READY;
               end
            end
            WAIT_READY: begin
`ifdef SCCB_CFG_TIMEOUT_EN
               wd_cnt <= wd_cnt + 32'd1;
               if (wd_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
                  error <= 1'b1;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= FINISH;
               end else
`endif
               if (sccb_ready) begin
                  sccb_start <= 1'b1;
                  state      <= WAIT_ACCEPT;
               end
            end
            WAIT_ACCEPT: begin
`ifdef SCCB_CFG_TIMEOUT_EN
               wd_cnt <= wd_cnt + 32'd1;
               if (wd_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
                  error <= 1'b1;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= FINISH;
               end else
`endif
               // Ready dropping low is the transmitter's acknowledgement of the request.
               if (!sccb_ready) begin
                  if (rom_addr == 8'hFF) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= FINISH;
                  end else begin
                     rom_addr <= rom_addr + 8'd1;
                     state    <= FETCH;
                  end
               end
            end
            DELAY: begin
               if (delay_cnt == 32'd0) begin
                  if (rom_addr == 8'hFF) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= FINISH;
                  end else begin
                     rom_addr <= rom_addr + 8'd1;
                     state    <= FETCH;
                  end
               end else begin
                  delay_cnt <= delay_cnt - 32'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ov7670_config_sequencer.sv
// Scoreboard bench for ov7670_config_sequencer: behavioural ROM and SCCB transmitter, expected writes queued per test.
module tb_ov7670_config_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  rom_addr;
   logic [15:0] rom_dout;
   logic        sccb_ready = 1'b1;
   logic        sccb_start;
   logic [7:0]  sccb_reg;
   logic [7:0]  sccb_data;
   logic        busy;
   logic        done;
   logic        error;

   int checks = 0;
   int errors = 0;
   int cycle = 0;
   int start_count = 0;
   int last_start_cycle = 0;
   bit prev_start = 1'b0;
   bit auto_ready = 1'b1;
   logic [15:0] rom [256];
   logic [15:0] exp_q [$];

   ov7670_config_sequencer #(.DELAY_CYCLES(10), .TIMEOUT_CYCLES(100)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .rom_addr(rom_addr), .rom_dout(rom_dout),
      .sccb_ready(sccb_ready), .sccb_start(sccb_start), .sccb_reg(sccb_reg),
      .sccb_data(sccb_data), .busy(busy), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   // Synchronous ROM: one cycle read latency.
   always @(posedge clk) rom_dout <= rom[rom_addr];

   initial forever begin
      @(posedge clk);
      cycle++;
   end

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // Transmitter model: after accepting a request, ready goes low for 3 cycles.
   initial forever begin
      @(negedge clk);
      if (rst_n && sccb_start && auto_ready) begin
         @(posedge clk);
         #1 sccb_ready = 1'b0;
         repeat (3) @(posedge clk);
         #1 sccb_ready = 1'b1;
      end
   end

   // Monitor: each write request is popped from the scoreboard and compared.
   initial forever begin
      @(negedge clk);
      if (rst_n && sccb_start) begin
         start_count++;
         last_start_cycle = cycle;
         if (prev_start) check_output("start_width", 32'd2, 32'd1);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_start: got reg/data %02h%02h, required no request", sccb_reg, sccb_data);
         end else begin
            check_output("sccb_write", {16'd0, sccb_reg, sccb_data}, {16'd0, exp_q.pop_front()});
         end
      end
      prev_start = sccb_start;
   end

   task automatic clear_rom();
      for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
   endtask

   task automatic apply_stimulus(output int k);
      @(posedge clk);
      #1 start = 1'b1;
      k = cycle + 1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int limit);
      int n;
      n = 0;
      while (!done && n < limit) begin
         @(posedge clk);
         #1 n++;
      end
      check_output({name, "_done"}, {31'd0, done}, 32'd1);
   endtask

   initial begin
      int k, sc, bad;
      clear_rom();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      check_output("reset_busy", {31'd0, busy}, 32'd0);
      check_output("reset_done", {31'd0, done}, 32'd0);
      check_output("reset_error", {31'd0, error}, 32'd0);
      check_output("reset_addr", {24'd0, rom_addr}, 32'd0);
      check_output("reset_regdata", {16'd0, sccb_reg, sccb_data}, 32'd0);
      check_output("reset_start", {31'd0, sccb_start}, 32'd0);

      // Single write then terminator.
      clear_rom();
      rom[0] = 16'h1280;
      exp_q.push_back(16'h1280);
      sc = start_count;
      apply_stimulus(k);
      check_output("t1_busy", {31'd0, busy}, 32'd1);
      wait_done("t1", 200);
      check_output("t1_busy_end", {31'd0, busy}, 32'd0);
      check_output("t1_count", start_count - sc, 32'd1);
      check_output("t1_queue", exp_q.size(), 32'd0);
      repeat (5) @(posedge clk);
      #1 check_output("t1_done_held", {31'd0, done}, 32'd1);

      // Delay entry ahead of a write.
      clear_rom();
      rom[0] = 16'hFFF0;
      rom[1] = 16'h1100;
      exp_q.push_back(16'h1100);
      sc = start_count;
      apply_stimulus(k);
      wait_done("t2", 200);
      check_output("t2_count", start_count - sc, 32'd1);
      check_output("t2_delay_ok", {31'd0, last_start_cycle >= k + 11}, 32'd1);

      // Transmitter busy for 50 cycles.
      clear_rom();
      rom[0] = 16'h3A04;
      exp_q.push_back(16'h3A04);
      auto_ready = 1'b0;
      sccb_ready = 1'b0;
      sc = start_count;
      apply_stimulus(k);
      bad = 0;
      repeat (4) @(posedge clk);
      for (int i = 0; i < 46; i++) begin
         @(posedge clk);
         #1 if ({sccb_reg, sccb_data} !== 16'h3A04) bad++;
      end
      check_output("t3_stable", bad, 32'd0);
      check_output("t3_withheld", start_count - sc, 32'd0);
      auto_ready = 1'b1;
      sccb_ready = 1'b1;
      wait_done("t3", 200);
      check_output("t3_count", start_count - sc, 32'd1);

      // Reset during DELAY aborts; a new start restarts at address 0.
      clear_rom();
      rom[0] = 16'hFFF0;
      rom[1] = 16'h5566;
      sc = start_count;
      apply_stimulus(k);
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      check_output("t4_rst_busy", {31'd0, busy}, 32'd0);
      check_output("t4_rst_addr", {24'd0, rom_addr}, 32'd0);
      repeat (20) @(posedge clk);
      check_output("t4_no_stray", start_count - sc, 32'd0);
      exp_q.push_back(16'h5566);
      apply_stimulus(k);
      check_output("t4_restart_addr", {24'd0, rom_addr}, 32'd0);
      wait_done("t4", 200);
      check_output("t4_count", start_count - sc, 32'd1);

      // Full ROM of writes, no terminator.
      for (int i = 0; i < 256; i++) begin
         rom[i] = {8'(i), ~8'(i)};
         exp_q.push_back({8'(i), ~8'(i)});
      end
      sc = start_count;
      apply_stimulus(k);
      wait_done("t5", 5000);
      check_output("t5_count", start_count - sc, 32'd256);
      check_output("t5_queue", exp_q.size(), 32'd0);
      check_output("t5_addr", {24'd0, rom_addr}, 32'd255);
      repeat (10) @(posedge clk);
      check_output("t5_no_wrap", start_count - sc, 32'd256);

`ifdef SCCB_CFG_TIMEOUT_EN
      // Watchdog fires after 100 cycles in WAIT_READY.
      clear_rom();
      rom[0] = 16'h1234;
      auto_ready = 1'b0;
      sccb_ready = 1'b0;
      apply_stimulus(k);
      wait_done("t6", 300);
      check_output("t6_cycle", cycle, k + 102);
      check_output("t6_error", {31'd0, error}, 32'd1);
      auto_ready = 1'b1;
      sccb_ready = 1'b1;
      exp_q.push_back(16'h1234);
      apply_stimulus(k);
      check_output("t6_clr_error", {31'd0, error}, 32'd0);
      check_output("t6_clr_done", {31'd0, done}, 32'd0);
      wait_done("t6b", 200);
      check_output("t6b_error", {31'd0, error}, 32'd0);
`endif

      repeat (5) @(posedge clk);
      check_output("final_queue", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
